// File: rtl/btn_cond.sv
// Push-button conditioner: 2-flop synchronizer, debounce FSM, registered level/press/release.
// Define BTN_COND_REPEAT_EN to add auto-repeat press pulses while the button is held.
module btn_cond #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ST_RELEASED     = 2'd0;
  localparam logic [1:0] ST_PRESS_PEND   = 2'd1;
  localparam logic [1:0] ST_HELD         = 2'd2;
  localparam logic [1:0] ST_RELEASE_PEND = 2'd3;

  logic             sync1_q, sync2_q;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, release_q;
  logic             press_fsm, release_d;
  logic             rpt_fire;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_fsm = 1'b0;
    release_d = 1'b0;
    case (state_q)
      ST_RELEASED: begin
        if (sync2_q) begin
          state_d = ST_PRESS_PEND;
          cnt_d   = '0;
        end
      end
      ST_PRESS_PEND: begin
        if (!sync2_q) begin
          state_d = ST_RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d   = ST_HELD;
          cnt_d     = '0;
          press_fsm = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HELD: begin
        if (!sync2_q) begin
          state_d = ST_RELEASE_PEND;
          cnt_d   = '0;
        end
      end
      ST_RELEASE_PEND: begin
        if (sync2_q) begin
          state_d = ST_HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d   = ST_RELEASED;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_RELEASED;
        cnt_d   = '0;
      end
    endcase
    level_d = (state_d == ST_HELD) || (state_d == ST_RELEASE_PEND);
  end

`ifdef BTN_COND_REPEAT_EN
  localparam logic [31:0] RPT_FIRST = 32'(REPEAT_DELAY - 1);
  localparam logic [31:0] RPT_STEP  = 32'(REPEAT_PERIOD);

  // rtgt_q holds the rcnt value at which the next repeat fires; avoids a modulo.
  logic [31:0] rcnt_q, rcnt_d, rtgt_q, rtgt_d;

  always_comb begin
    rcnt_d   = rcnt_q;
    rtgt_d   = rtgt_q;
    rpt_fire = 1'b0;
    if (state_q == ST_PRESS_PEND && state_d == ST_HELD) begin
      rcnt_d = '0;
      rtgt_d = RPT_FIRST;
    end else if (state_q == ST_HELD) begin
      if (rcnt_q != '1) rcnt_d = rcnt_q + 32'd1;
      if (sync2_q && rcnt_q == rtgt_q && rcnt_q != '1) begin
        rpt_fire = 1'b1;
        rtgt_d   = (rtgt_q > (32'hFFFF_FFFF - RPT_STEP)) ? '1 : rtgt_q + RPT_STEP;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt_q <= '0;
      rtgt_q <= RPT_FIRST;
    end else begin
      rcnt_q <= rcnt_d;
      rtgt_q <= rtgt_d;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RELEASED;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_fsm | rpt_fire;
      release_q <= release_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

endmodule

// File: tb/tb_btn_cond.sv
// Self-checking bench for btn_cond: segment table plus hand-written reset and repeat sequences.
module tb_btn_cond;

  localparam int DB = 4;
  localparam int RD = 8;
  localparam int RP = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_raw;
  logic btn_level, btn_press, btn_release;

  btn_cond #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  always #5 clk = ~clk;

  // exp packs {btn_level, btn_press, btn_release}
  typedef struct {
    logic       raw;
    int         n;
    logic [2:0] exp;
    string      name;
  } seg_t;

  typedef struct {
    logic [2:0] exp;
    string      name;
  } sb_t;

  seg_t tbl[$];
  sb_t  sb_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got level/press/release=%b expected %b", name, act, exp);
    end
  endtask

  task automatic add_seg(input logic raw, input int n, input logic [2:0] exp, input string name);
    seg_t s;
    s.raw = raw; s.n = n; s.exp = exp; s.name = name;
    tbl.push_back(s);
  endtask

  // Called at a falling edge; drives one cycle and compares just after the rising edge.
  task automatic step(input logic raw, input logic [2:0] exp, input string name);
    sb_t e;
    btn_raw = raw;
    e.exp = exp; e.name = name;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check(e.name, {btn_level, btn_press, btn_release}, e.exp);
    @(negedge clk);
  endtask

  task automatic run_segs(input int first, input int last);
    for (int i = first; i <= last; i++)
      for (int c = 0; c < tbl[i].n; c++)
        step(tbl[i].raw, tbl[i].exp, tbl[i].name);
  endtask

  initial begin
    logic rep;
    // 0-2: clean press, press pulse after edge E+6
    add_seg(1'b1, 6, 3'b000, "press_wait");
    add_seg(1'b1, 1, 3'b110, "press_pulse");
    add_seg(1'b1, 3, 3'b100, "press_held");
    // 3-5: release, release pulse after edge R+6
    add_seg(1'b0, 6, 3'b100, "release_wait");
    add_seg(1'b0, 1, 3'b001, "release_pulse");
    add_seg(1'b0, 3, 3'b000, "release_idle");
    // 6-9: bounce 3 high, 1 low, 2 high, then low
    add_seg(1'b1, 3, 3'b000, "bounce_hi3");
    add_seg(1'b0, 1, 3'b000, "bounce_lo1");
    add_seg(1'b1, 2, 3'b000, "bounce_hi2");
    add_seg(1'b0, 8, 3'b000, "bounce_settle");
    // 10-14: press, then a 2-cycle release bounce while held
    add_seg(1'b1, 6, 3'b000, "hold_wait");
    add_seg(1'b1, 1, 3'b110, "hold_pulse");
    add_seg(1'b1, 2, 3'b100, "hold_held");
    add_seg(1'b0, 2, 3'b100, "rel_bounce_lo");
    add_seg(1'b1, 3, 3'b100, "rel_bounce_hi");
    // 15-16: re-arm after reset with the button still down
    add_seg(1'b1, 6, 3'b000, "rearm_wait");
    add_seg(1'b1, 1, 3'b110, "rearm_pulse");
    // 17-19: final release after the long hold
    add_seg(1'b0, 6, 3'b100, "final_rel_wait");
    add_seg(1'b0, 1, 3'b001, "final_rel_pulse");
    add_seg(1'b0, 2, 3'b000, "final_rel_idle");

    rst_n   = 1'b0;
    btn_raw = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", {btn_level, btn_press, btn_release}, 3'b000);
    rst_n = 1'b1;
    step(1'b0, 3'b000, "idle");
    step(1'b0, 3'b000, "idle");

    run_segs(0, 14);

    // Reset while held: outputs clear before any clock edge.
    rst_n = 1'b0;
    #1;
    check("async_reset", {btn_level, btn_press, btn_release}, 3'b000);
    @(posedge clk);
    #1;
    check("reset_held", {btn_level, btn_press, btn_release}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    run_segs(15, 16);

    // Long hold: repeats at press+8, +12, ... only in the repeat build.
    for (int k = 1; k <= 32; k++) begin
`ifdef BTN_COND_REPEAT_EN
      rep = (k >= RD) && (((k - RD) % RP) == 0);
`else
      rep = 1'b0;
`endif
      step(1'b1, {1'b1, rep, 1'b0}, $sformatf("long_hold_%0d", k));
    end

    run_segs(17, 19);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
